// File: rtl/waveform_seq_pkg.sv
// Shared types and sizing for the waveform segment sequencer.
// The table entry layout is fixed by the localparams below, which match the top-level defaults.
package waveform_seq_pkg;

  localparam int ADDR_W    = 14;
  localparam int LEN_W     = ADDR_W + 1;
  localparam int REP_W     = 16;
  localparam int NUM_SEG   = 8;
  localparam int SEG_IDX_W = $clog2(NUM_SEG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // "repeat" is a reserved word, so the field is named rpt.
  typedef struct packed {
    logic [ADDR_W-1:0] start;
    logic [LEN_W-1:0]  len;
    logic [REP_W-1:0]  rpt;
  } seg_entry_t;

endpackage

// File: rtl/waveform_seq_table.sv
// Segment table register file: synchronous write, combinational read.
// Reset clears every entry, so an unwritten entry reads as an end-of-list marker.
module waveform_seq_table
  import waveform_seq_pkg::*;
#(
  parameter int NUM_SEGMENTS = NUM_SEG
) (
  input  logic                            sample_clk,
  input  logic                            sample_rst,
  input  logic                            we,
  input  logic [$clog2(NUM_SEGMENTS)-1:0] wr_idx,
  input  seg_entry_t                      wr_data,
  input  logic [$clog2(NUM_SEGMENTS)-1:0] rd_idx,
  output seg_entry_t                      rd_data
);

  seg_entry_t table_q [NUM_SEGMENTS];

  always_ff @(posedge sample_clk) begin
    if (sample_rst) begin
      for (int i = 0; i < NUM_SEGMENTS; i++) table_q[i] <= '0;
    end else if (we) begin
      table_q[wr_idx] <= wr_data;
    end
  end

  // A read in the same cycle as a write to that index returns the old entry.
  assign rd_data = table_q[rd_idx];

endmodule

// File: rtl/waveform_segment_sequencer.sv
// Segment-based playback scheduler: walks the segment table and issues one
// buffer read address per accepted beat, with per-segment repeat, list looping and abort.
module waveform_segment_sequencer
  import waveform_seq_pkg::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter int NUM_SEGMENTS = 8,
  parameter int REPEAT_WIDTH = 16
) (
  input  logic                            sample_clk,
  input  logic                            sample_rst,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_SEGMENTS)-1:0] cfg_idx,
  input  logic [ADDR_WIDTH-1:0]           cfg_start,
  input  logic [ADDR_WIDTH:0]             cfg_len,
  input  logic [REPEAT_WIDTH-1:0]         cfg_repeat,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            loop_en,
  output logic [ADDR_WIDTH-1:0]           m_rd_addr,
  output logic                            m_rd_valid,
  input  logic                            m_rd_ready,
  output logic [$clog2(NUM_SEGMENTS)-1:0] seg_idx,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int IDX_W = $clog2(NUM_SEGMENTS);
  localparam logic [IDX_W-1:0] LAST_SEG = IDX_W'(NUM_SEGMENTS - 1);

  seq_state_t state;
  seg_entry_t wr_entry;
  seg_entry_t rd_entry;

  logic [ADDR_WIDTH:0]     remaining;
  logic [REPEAT_WIDTH-1:0] rep;
  logic [ADDR_WIDTH-1:0]   lat_start;
  logic [ADDR_WIDTH:0]     lat_len;

  assign wr_entry = '{start: cfg_start, len: cfg_len, rpt: cfg_repeat};

  waveform_seq_table #(
    .NUM_SEGMENTS(NUM_SEGMENTS)
  ) u_table (
    .sample_clk(sample_clk),
    .sample_rst(sample_rst),
    .we        (cfg_we),
    .wr_idx    (cfg_idx),
    .wr_data   (wr_entry),
    .rd_idx    (seg_idx),
    .rd_data   (rd_entry)
  );

  // Counters and latched segment values carry no reset; they are always
  // loaded in LOAD before PLAY can consume them.
  always_ff @(posedge sample_clk) begin
    if (sample_rst) begin
      state      <= IDLE;
      seg_idx    <= '0;
      m_rd_addr  <= '0;
      m_rd_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state   <= LOAD;
            seg_idx <= '0;
            busy    <= 1'b1;
          end
        end

        LOAD: begin
          if (stop) begin
            state      <= IDLE;
            m_rd_valid <= 1'b0;
            busy       <= 1'b0;
          end else begin
            lat_start <= rd_entry.start;
            lat_len   <= rd_entry.len;
            m_rd_addr <= rd_entry.start;
            remaining <= rd_entry.len;
            rep       <= (rd_entry.rpt == '0) ? REPEAT_WIDTH'(1) : rd_entry.rpt;
            if (rd_entry.len == '0) begin
              if (seg_idx == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
                err   <= 1'b1;
              end else if (loop_en) begin
                seg_idx <= '0;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              state      <= PLAY;
              m_rd_valid <= 1'b1;
            end
          end
        end

        PLAY: begin
          if (stop) begin
            state      <= IDLE;
            m_rd_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (m_rd_ready) begin
            if (remaining > (ADDR_WIDTH+1)'(1)) begin
              m_rd_addr <= m_rd_addr + 1'b1;
              remaining <= remaining - 1'b1;
            end else if (rep > REPEAT_WIDTH'(1)) begin
              rep       <= rep - 1'b1;
              m_rd_addr <= lat_start;
              remaining <= lat_len;
            end else begin
              m_rd_valid <= 1'b0;
              if (seg_idx == LAST_SEG) begin
                if (loop_en) begin
                  seg_idx <= '0;
                  state   <= LOAD;
                end else begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end else begin
                seg_idx <= seg_idx + 1'b1;
                state   <= LOAD;
              end
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
